// File: rtl/sha2ipudpath.sv
// SHA-2 input datapath: 8x64 message register file, bit-length counter and a
// one-deep output block buffer. Define SHA2IPUDPATH_ERR_EN to enable the sticky err flag.
module sha2ipudpath (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  pkt,
  input  logic         st_pkt,
  input  logic         pad_pkt,
  input  logic         zero_pkt,
  input  logic         mgln_pkt,
  input  logic         blk_val,
  input  logic         msg_end,
  output logic [2:0]   idx,
  output logic [511:0] blk,
  output logic         out_val,
  output logic         out_last,
  input  logic         out_rdy,
  output logic         buf_full,
  output logic         err
);

  localparam logic [63:0] PAD_WORD = 64'h8000_0000_0000_0000;

  logic [63:0]  words [8];
  logic [63:0]  len;
  logic [63:0]  wr_data;
  logic [511:0] snap;
  logic         wr_en;
  logic         st_sel;
  logic         cap;

  assign wr_en  = st_pkt | pad_pkt | zero_pkt | mgln_pkt;
  // pkt is only written (and counted) when no higher-priority strobe wins
  assign st_sel = st_pkt & ~pad_pkt & ~zero_pkt & ~mgln_pkt;

  always_comb begin
    wr_data = pkt;
    if (mgln_pkt)      wr_data = len;
    else if (zero_pkt) wr_data = '0;
    else if (pad_pkt)  wr_data = PAD_WORD;
  end

  always_comb begin
    snap = '0;
    for (int i = 0; i < 8; i++) snap[511-64*i -: 64] = words[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) words[i] <= '0;
      idx <= '0;
    end else if (wr_en) begin
      words[idx] <= wr_data;
      idx        <= idx + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          len <= '0;
    else if (mgln_pkt) len <= '0;
    else if (st_sel)   len <= len + 64'd64;
  end

  // snap is sampled pre-edge, so a word-0 write on the capture edge lands in the next block
  assign cap = blk_val & (~out_val | out_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk      <= '0;
      out_val  <= 1'b0;
      out_last <= 1'b0;
    end else if (cap) begin
      blk      <= snap;
      out_val  <= 1'b1;
      out_last <= msg_end;
    end else if (out_val && out_rdy) begin
      out_val  <= 1'b0;
    end
  end

  assign buf_full = out_val;

`ifdef SHA2IPUDPATH_ERR_EN
  logic ovf;
  logic wrap;
  assign ovf  = blk_val & out_val & ~out_rdy;
  // len >= 2^64-64 exactly when bits [63:6] are all ones
  assign wrap = st_sel & (&len[63:6]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err <= 1'b0;
    else if (ovf || wrap) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha2ipudpath.sv
// Scoreboard bench for sha2ipudpath: expected blocks are queued at stimulus time
// and a negedge monitor compares them whenever a transfer handshake occurs.
module tb_sha2ipudpath;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  pkt = '0;
  logic         st_pkt = 1'b0, pad_pkt = 1'b0, zero_pkt = 1'b0, mgln_pkt = 1'b0;
  logic         blk_val = 1'b0, msg_end = 1'b0;
  logic [2:0]   idx;
  logic [511:0] blk;
  logic         out_val, out_last, buf_full, err;
  logic         out_rdy = 1'b1;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  sha2ipudpath dut (
    .clk(clk), .rst(rst), .pkt(pkt), .st_pkt(st_pkt), .pad_pkt(pad_pkt),
    .zero_pkt(zero_pkt), .mgln_pkt(mgln_pkt), .blk_val(blk_val), .msg_end(msg_end),
    .idx(idx), .blk(blk), .out_val(out_val), .out_last(out_last), .out_rdy(out_rdy),
    .buf_full(buf_full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [511:0] mk(input logic [63:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w0, w1, w2, w3, w4, w5, w6, w7};
  endfunction

  // one clock of stimulus; strobes clear again just after the edge
  task automatic cyc(input logic s, p, z, m, bv, me, input logic [63:0] d);
    st_pkt = s; pad_pkt = p; zero_pkt = z; mgln_pkt = m;
    blk_val = bv; msg_end = me; pkt = d;
    @(posedge clk); #1;
    st_pkt = 0; pad_pkt = 0; zero_pkt = 0; mgln_pkt = 0;
    blk_val = 0; msg_end = 0; pkt = '0;
  endtask

  task automatic st(input logic [63:0] d);  cyc(1, 0, 0, 0, 0, 0, d);  endtask
  task automatic pad();                     cyc(0, 1, 0, 0, 0, 0, '0); endtask
  task automatic zro();                     cyc(0, 0, 1, 0, 0, 0, '0); endtask
  task automatic mgln();                    cyc(0, 0, 0, 1, 0, 0, '0); endtask
  task automatic bval(input logic me);      cyc(0, 0, 0, 0, 1, me, '0); endtask
  task automatic idle();                    cyc(0, 0, 0, 0, 0, 0, '0); endtask

  // seven st_pkt words base..base+6 followed by the length word
  task automatic blk7(input logic [63:0] base);
    for (int i = 0; i < 7; i++) st(base + 64'(i));
    mgln();
  endtask

  always @(negedge clk) begin
    if (!rst && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_xfer: got blk %h want none", blk);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer_blk", blk, e.data);
        chk("xfer_last", 512'(out_last), 512'(e.last));
      end
    end
  end

  logic exp_err;

  initial begin
`ifdef SHA2IPUDPATH_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #12;
    chk("rst_idx", 512'(idx), 512'(0));
    chk("rst_val", 512'(out_val), 512'(0));
    chk("rst_last", 512'(out_last), 512'(0));
    chk("rst_blk", blk, '0);
    chk("rst_err", 512'(err), 512'(0));
    @(posedge clk); #1; rst = 0;

    // basic block: words 1..7 plus length 448
    blk7(64'd1);
    exp_q.push_back('{mk(1, 2, 3, 4, 5, 6, 7, 64'h1C0), 1'b0});
    bval(0);
    chk("t1_val", 512'(out_val), 512'(1));
    chk("t1_full", 512'(buf_full), 512'(1));
    chk("t1_idx", 512'(idx), 512'(0));
    idle();
    chk("t1_val_clr", 512'(out_val), 512'(0));

    // 3-packet message with padding, last block
    st(64'h0123_4567_89AB_CDEF); st(64'hFEDC_BA98_7654_3210); st(64'h1111_2222_3333_4444);
    pad(); zro(); zro(); zro(); mgln();
    exp_q.push_back('{mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                         64'h1111_2222_3333_4444, 64'h8000_0000_0000_0000,
                         0, 0, 0, 64'd192), 1'b1});
    bval(1);
    chk("t2_last", 512'(out_last), 512'(1));
    idle();

    // stall: output must hold; overflow blk_val ignored
    blk7(64'h10);
    out_rdy = 0;
    exp_q.push_back('{mk(64'h10, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h1C0), 1'b0});
    bval(0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("t3_stall_val", 512'(out_val), 512'(1));
      chk("t3_stall_blk", blk, mk(64'h10, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h1C0));
    end
    chk("t3_err_pre", 512'(err), 512'(0));
    blk7(64'h70);
    bval(1);
    chk("t3_ovf_blk", blk, mk(64'h10, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h1C0));
    chk("t3_ovf_last", 512'(out_last), 512'(0));
    chk("t3_err", 512'(err), 512'(exp_err));
    out_rdy = 1;
    idle();
    chk("t3_val_clr", 512'(out_val), 512'(0));

    // st+mgln together at idx 7: length wins, counter clears
    for (int i = 0; i < 7; i++) st(64'h20 + 64'(i));
    chk("t4_idx7", 512'(idx), 512'(7));
    cyc(1, 0, 0, 1, 0, 0, 64'hDEAD);
    chk("t4_idx0", 512'(idx), 512'(0));
    exp_q.push_back('{mk(64'h20, 64'h21, 64'h22, 64'h23, 64'h24, 64'h25, 64'h26, 64'h1C0), 1'b0});
    bval(0);
    idle();
    st(64'h30); for (int i = 0; i < 6; i++) zro(); mgln();
    exp_q.push_back('{mk(64'h30, 0, 0, 0, 0, 0, 0, 64'd64), 1'b1});
    bval(1);
    idle();

    // async reset mid-block with a full buffer
    out_rdy = 0;
    blk7(64'h90);
    bval(0);
    for (int i = 0; i < 4; i++) st(64'hA0 + 64'(i));
    chk("t5_pre_val", 512'(out_val), 512'(1));
    chk("t5_pre_idx", 512'(idx), 512'(4));
    #2 rst = 1;
    #1;
    chk("t5_rst_idx", 512'(idx), 512'(0));
    chk("t5_rst_val", 512'(out_val), 512'(0));
    chk("t5_rst_blk", blk, '0);
    @(posedge clk); #1; rst = 0; out_rdy = 1;
    blk7(64'h40);
    exp_q.push_back('{mk(64'h40, 64'h41, 64'h42, 64'h43, 64'h44, 64'h45, 64'h46, 64'h1C0), 1'b0});
    bval(0);
    idle();

    // back-to-back: word 0 of next block written on the capture edge
    blk7(64'h50);
    exp_q.push_back('{mk(64'h50, 64'h51, 64'h52, 64'h53, 64'h54, 64'h55, 64'h56, 64'h1C0), 1'b0});
    cyc(1, 0, 0, 0, 1, 0, 64'h60);
    for (int i = 1; i < 7; i++) st(64'h60 + 64'(i));
    mgln();
    exp_q.push_back('{mk(64'h60, 64'h61, 64'h62, 64'h63, 64'h64, 64'h65, 64'h66, 64'h1C0), 1'b1});
    bval(1);
    idle(); idle();

    chk("queue_empty", 512'(exp_q.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
